// File: rtl/modport_fifo_pkg.sv
// rtl/modport_fifo_pkg.sv - shared constants, flag type and flag decode for the FIFO
// Purpose: one place for the FIFO geometry so the interface, the RTL and the
//          bench agree on widths. No ports.
package fifo_define_pkg;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 16;
  localparam int ALM_MARGIN = 2;
  localparam int ADDR_W     = $clog2(DEPTH);

  typedef struct packed {
    logic full;
    logic alm_full;
    logic empty;
    logic alm_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, alm_full: 1'b0,
                                          empty: 1'b1, alm_empty: 1'b1};

  // Status decode from an occupancy value.
  function automatic fifo_flags_t decode_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned margin);
    fifo_flags_t f;
    f.full      = (cnt == depth);
    f.alm_full  = (cnt >= depth - margin);
    f.empty     = (cnt == 0);
    f.alm_empty = (cnt <= margin);
    return f;
  endfunction

endpackage

// File: rtl/modport_fifo_if.sv
// rtl/modport_fifo_if.sv - push/pop and status bundle between driver and FIFO
// Purpose: groups the FIFO request, data and flag signals.
// Modports:
//   master : driver side  - drives i_wren/i_rden/i_wrdata, observes o_*
//   slave  : FIFO side    - observes i_*, drives o_rddata and the four flags
//   monitor: passive side - observes everything
interface fifo_if #(
  parameter int DATA_W = fifo_define_pkg::DATA_W
) ();

  logic              i_wren;
  logic              i_rden;
  logic [DATA_W-1:0] i_wrdata;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_alm_full;
  logic              o_empty;
  logic              o_alm_empty;

  modport master (
    output i_wren, i_rden, i_wrdata,
    input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty
  );

  modport slave (
    input  i_wren, i_rden, i_wrdata,
    output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty
  );

  modport monitor (
    input i_wren, i_rden, i_wrdata,
    input o_rddata, o_full, o_alm_full, o_empty, o_alm_empty
  );

endinterface

// File: rtl/modport_fifo_mem.sv
// rtl/modport_fifo_mem.sv - dual-port register array with registered read port
// Purpose: FIFO storage. The array itself is not reset; only the read
//          register is, so the FIFO output starts at zero.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata     : write port
//   re, raddr, rdata     : read port, rdata updates one edge after re
module fifo_mem #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // A same-edge write to raddr (full + simultaneous push/pop) is not seen
  // here: the read returns the old word, which is the oldest entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - single-clock FIFO with registered read data and status flags
// Purpose: pointer, occupancy and accept logic around fifo_mem.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : fifo_if.slave - i_wren/i_rden/i_wrdata in; o_rddata, o_full,
//          o_alm_full, o_empty, o_alm_empty out
// DEPTH must be a power of two >= 4; 1 <= ALM_MARGIN < DEPTH/2.
module modport_fifo #(
  parameter int DATA_W     = fifo_define_pkg::DATA_W,
  parameter int DEPTH      = fifo_define_pkg::DEPTH,
  parameter int ALM_MARGIN = fifo_define_pkg::ALM_MARGIN
) (
  input  logic   clk,
  input  logic   rstn,
  fifo_if.slave  bus
);

  import fifo_define_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  fifo_flags_t   flags_q, flags_d;
  logic          wr_ok, rd_ok;

  always_comb begin
    // A write into a full FIFO is still taken when a read frees the slot
    // on the same edge.
    rd_ok   = bus.i_rden && !flags_q.empty;
    wr_ok   = bus.i_wren && (!flags_q.full || bus.i_rden);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
    // Flags are registered from the next count so they change only on the edge.
    flags_d = decode_flags(32'(count_d), DEPTH, ALM_MARGIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (bus.i_wrdata),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdata (bus.o_rddata)
  );

  assign bus.o_full      = flags_q.full;
  assign bus.o_alm_full  = flags_q.alm_full;
  assign bus.o_empty     = flags_q.empty;
  assign bus.o_alm_empty = flags_q.alm_empty;

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - self-checking bench for modport_fifo
module tb_modport_fifo;

  import fifo_define_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  fifo_if bus ();

  modport_fifo dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit              w;
    bit              r;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_rd;
    int              exp_cnt;
  } vec_t;

  vec_t tbl[$];

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags implied by an occupancy value.
  task automatic check_cnt(input string tag, input int c);
    check({tag, ".empty"},     32'(bus.o_empty),     32'(c == 0));
    check({tag, ".alm_empty"}, 32'(bus.o_alm_empty), 32'(c <= ALM_MARGIN));
    check({tag, ".alm_full"},  32'(bus.o_alm_full),  32'(c >= DEPTH - ALM_MARGIN));
    check({tag, ".full"},      32'(bus.o_full),      32'(c == DEPTH));
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rddata"}, 32'(bus.o_rddata), 32'(m_rd));
    check_cnt(tag, q.size());
  endtask

  // One clock: apply request, update the queue model, leave outputs settled.
  task automatic drive(input bit w, input bit r, input logic [DATA_W-1:0] d);
    bit rd_ok, wr_ok;
    bus.i_wren   = w;
    bus.i_rden   = r;
    bus.i_wrdata = d;
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < DEPTH) || r);
    @(posedge clk);
    #1;
    if (rd_ok) m_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    bus.i_wren = 1'b0;
    bus.i_rden = 1'b0;
  endtask

  function automatic vec_t mk(input bit w, input bit r, input int d, input int rd, input int c);
    vec_t v;
    v.w = w; v.r = r; v.d = DATA_W'(d); v.exp_rd = DATA_W'(rd); v.exp_cnt = c;
    return v;
  endfunction

  initial begin
    int p_w, p_r;
    bus.i_wren   = 1'b0;
    bus.i_rden   = 1'b0;
    bus.i_wrdata = '0;
    m_rd = '0;

    // Fill, overflow, drain, underflow, simultaneous push/pop while empty.
    for (int i = 1; i <= DEPTH; i++) tbl.push_back(mk(1, 0, i, 0, i));
    tbl.push_back(mk(1, 0, 'hFF, 0, DEPTH));
    for (int i = 1; i <= DEPTH; i++) tbl.push_back(mk(0, 1, 0, i, DEPTH - i));
    tbl.push_back(mk(0, 1, 0, DEPTH, 0));
    tbl.push_back(mk(1, 1, 'hAA, DEPTH, 1));
    tbl.push_back(mk(0, 1, 0, 'hAA, 0));

    // Reset
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("reset.rddata", 32'(bus.o_rddata), 32'h0);
    check_cnt("reset", 0);

    foreach (tbl[i]) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].d);
      check($sformatf("tbl%0d.rddata", i), 32'(bus.o_rddata), 32'(tbl[i].exp_rd));
      check_cnt($sformatf("tbl%0d", i), tbl[i].exp_cnt);
    end

    // Simultaneous push/pop while full
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DATA_W'(8'h20 + i));
    check_model("fill2");
    drive(1, 1, DATA_W'(8'h55));
    check("fullrw.rddata", 32'(bus.o_rddata), 32'h20);
    check("fullrw.full", 32'(bus.o_full), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, '0);
      check_model($sformatf("drain2_%0d", i));
    end
    check("fullrw.last", 32'(bus.o_rddata), 32'h55);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 3; i++) drive(1, 0, DATA_W'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      drive(1, (i % 4) != 3, DATA_W'($urandom_range(0, 255)));
      check_model($sformatf("wrap%0d", i));
    end

    // Random phases biased toward full and toward empty
    for (int ph = 0; ph < 4; ph++) begin
      p_w = (ph % 2 == 0) ? 80 : 25;
      p_r = (ph % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 99) < p_w, $urandom_range(0, 99) < p_r,
              DATA_W'($urandom_range(0, 255)));
        check_model($sformatf("rnd%0d_%0d", ph, i));
      end
    end

    // Mid-operation asynchronous reset with 5 entries stored
    for (int i = 0; i <= DEPTH && q.size() != 0; i++) drive(0, 1, '0);
    check("pre_rst.empty", 32'(bus.o_empty), 32'h1);
    drive(1, 0, DATA_W'(8'h99));
    drive(0, 1, '0);
    for (int i = 0; i < 5; i++) drive(1, 0, DATA_W'(8'h70 + i));
    check_model("pre_rst");
    #2 rstn = 1'b0;
    #1;
    check("arst.rddata", 32'(bus.o_rddata), 32'h0);
    check_cnt("arst", 0);
    q.delete();
    m_rd = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, DATA_W'(8'h3C));
    check_model("post_rst.wr");
    drive(0, 1, '0);
    check("post_rst.rddata", 32'(bus.o_rddata), 32'h3C);
    check_cnt("post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
